// File: rtl/exe_issue_sched.sv
// Execute-stage issue scheduler: skid FIFO from decode feeding the shared ALU one micro-op at a time.
// Define EXE_ISSUE_SCHED_PERF_EN to add saturating performance counters.
module exe_issue_sched #(
   parameter int DEPTH   = 2,
   parameter int MUL_LAT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [9:0]  in_opcode,
   input  logic [63:0] in_oprd1,
   input  logic [63:0] in_oprd2,
   input  logic [63:0] in_oprd3,
   input  logic [63:0] in_next_rip,
   output logic        alu_enable,
   output logic [9:0]  alu_opcode,
   output logic [63:0] alu_oprd1,
   output logic [63:0] alu_oprd2,
   output logic [63:0] alu_oprd3,
   output logic [63:0] alu_next_rip,
   input  logic        mem_blocked,
   input  logic        alu_branch,
   output logic        busy
`ifdef EXE_ISSUE_SCHED_PERF_EN
   ,
   output logic [31:0] perf_issued,
   output logic [31:0] perf_stall,
   output logic [31:0] perf_flush,
   output logic [31:0] perf_spurious_br
`endif
);

   localparam int         AW       = $clog2(DEPTH);
   localparam logic [9:0] OPC_IMUL = 10'h0F7;
   localparam logic [3:0] MUL_INIT = 4'(MUL_LAT - 1);

   // ST_BRISSUE is the cycle the branch op itself occupies the ALU; ST_BRWAIT is the bubble after it.
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_MUL,
      ST_BRISSUE,
      ST_BRWAIT,
      ST_FLUSH
   } state_t;

   logic [9:0]  r_q_opc [DEPTH];
   logic [63:0] r_q_op1 [DEPTH];
   logic [63:0] r_q_op2 [DEPTH];
   logic [63:0] r_q_op3 [DEPTH];
   logic [63:0] r_q_rip [DEPTH];
   logic [AW:0] r_wr_ptr;
   logic [AW:0] r_rd_ptr;
   state_t      r_state;
   logic [3:0]  r_mcnt;
   logic        r_flush_q;

   state_t        w_state_nx;
   logic [3:0]    w_mcnt_nx;
   logic [AW:0]   w_count;
   logic [AW-1:0] w_head_idx;
   logic [9:0]    w_head_opc;
   logic          w_full;
   logic          w_empty;
   logic          w_head_avail;
   logic          w_push;
   logic          w_try;
   logic          w_load;
   logic          w_en_nx;
   logic          w_clear;
   logic [1:0]    w_pop;

   function automatic logic f_is_branch(input logic [9:0] op);
      return (op[9:4] == 6'h07) || (op[9:4] == 6'h18) ||
             (op == 10'h0E8) || (op == 10'h0E9) || (op == 10'h0EB) ||
             (op == 10'h0C3) || (op == 10'h310);
   endfunction

   assign w_count  = r_wr_ptr - r_rd_ptr;
   assign w_full   = (w_count == (AW+1)'(DEPTH));
   assign w_empty  = (w_count == '0);
   assign in_ready = !w_full && !r_flush_q;
   assign busy     = !w_empty || (r_state != ST_IDLE);
   assign w_push   = in_valid && in_ready;

   // An IMUL stays at the head until it retires, so the op behind it is the next candidate.
   assign w_head_idx   = (r_state == ST_MUL) ? r_rd_ptr[AW-1:0] + AW'(1) : r_rd_ptr[AW-1:0];
   assign w_head_avail = (r_state == ST_MUL) ? (w_count >= (AW+1)'(2)) : !w_empty;
   assign w_head_opc   = r_q_opc[w_head_idx];

   always_comb begin
      w_state_nx = r_state;
      w_mcnt_nx  = r_mcnt;
      w_en_nx    = alu_enable;
      w_load     = 1'b0;
      w_try      = 1'b0;
      w_clear    = 1'b0;
      w_pop      = 2'd0;
      case (r_state)
         ST_IDLE, ST_ISSUE: w_try = !mem_blocked;
         ST_MUL: begin
            if (!mem_blocked) begin
               if (r_mcnt == 4'd0) begin
                  w_pop = 2'd1;
                  w_try = 1'b1;
               end else begin
                  w_mcnt_nx = r_mcnt - 4'd1;
               end
            end
         end
         ST_BRISSUE: begin
            if (!mem_blocked) begin
               w_en_nx    = 1'b0;
               w_state_nx = ST_BRWAIT;
            end
         end
         ST_BRWAIT: begin
            if (alu_branch) begin
               w_en_nx    = 1'b0;
               w_state_nx = ST_FLUSH;
            end else begin
               w_try = !mem_blocked;
            end
         end
         ST_FLUSH: begin
            w_clear    = 1'b1;
            w_en_nx    = 1'b0;
            w_state_nx = ST_IDLE;
         end
         default: w_state_nx = ST_IDLE;
      endcase

      if (w_try) begin
         if (w_head_avail) begin
            w_load  = 1'b1;
            w_en_nx = 1'b1;
            if (w_head_opc == OPC_IMUL) begin
               w_state_nx = ST_MUL;
               w_mcnt_nx  = MUL_INIT;
            end else begin
               w_pop      = w_pop + 2'd1;
               w_state_nx = f_is_branch(w_head_opc) ? ST_BRISSUE : ST_ISSUE;
            end
         end else begin
            w_en_nx    = 1'b0;
            w_state_nx = ST_IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_q_opc[r_wr_ptr[AW-1:0]] <= in_opcode;
         r_q_op1[r_wr_ptr[AW-1:0]] <= in_oprd1;
         r_q_op2[r_wr_ptr[AW-1:0]] <= in_oprd2;
         r_q_op3[r_wr_ptr[AW-1:0]] <= in_oprd3;
         r_q_rip[r_wr_ptr[AW-1:0]] <= in_next_rip;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (w_clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         r_rd_ptr <= r_rd_ptr + (AW+1)'(w_pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_mcnt       <= 4'd0;
         r_flush_q    <= 1'b0;
         alu_enable   <= 1'b0;
         alu_opcode   <= '0;
         alu_oprd1    <= '0;
         alu_oprd2    <= '0;
         alu_oprd3    <= '0;
         alu_next_rip <= '0;
      end else begin
         r_state    <= w_state_nx;
         r_mcnt     <= w_mcnt_nx;
         r_flush_q  <= (w_state_nx == ST_FLUSH);
         alu_enable <= w_en_nx;
         if (w_load) begin
            alu_opcode   <= w_head_opc;
            alu_oprd1    <= r_q_op1[w_head_idx];
            alu_oprd2    <= r_q_op2[w_head_idx];
            alu_oprd3    <= r_q_op3[w_head_idx];
            alu_next_rip <= r_q_rip[w_head_idx];
         end
      end
   end

`ifdef EXE_ISSUE_SCHED_PERF_EN
   function automatic logic [31:0] f_sat_inc(input logic [31:0] v, input logic inc);
      return (inc && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_issued      <= '0;
         perf_stall       <= '0;
         perf_flush       <= '0;
         perf_spurious_br <= '0;
      end else begin
         perf_issued      <= f_sat_inc(perf_issued, w_load);
         perf_stall       <= f_sat_inc(perf_stall, mem_blocked && busy);
         perf_flush       <= f_sat_inc(perf_flush, (w_state_nx == ST_FLUSH) && (r_state != ST_FLUSH));
         perf_spurious_br <= f_sat_inc(perf_spurious_br, alu_branch && (r_state != ST_BRWAIT));
      end
   end
`endif

endmodule

// File: tb/tb_exe_issue_sched.sv
// Directed bench for exe_issue_sched with a scoreboard of expected ALU beats.
module tb_exe_issue_sched;

   localparam int DEPTH   = 2;
   localparam int MUL_LAT = 4;

   localparam logic [9:0] OP_ADD  = 10'h000;
   localparam logic [9:0] OP_OR   = 10'h008;
   localparam logic [9:0] OP_SUB  = 10'h028;
   localparam logic [9:0] OP_XOR  = 10'h030;
   localparam logic [9:0] OP_JMP  = 10'h0E9;
   localparam logic [9:0] OP_IMUL = 10'h0F7;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [9:0]  in_opcode;
   logic [63:0] in_oprd1, in_oprd2, in_oprd3, in_next_rip;
   logic        alu_enable;
   logic [9:0]  alu_opcode;
   logic [63:0] alu_oprd1, alu_oprd2, alu_oprd3, alu_next_rip;
   logic        mem_blocked;
   logic        alu_branch;
   logic        busy;

   int n_assert = 0;
   int n_fail   = 0;

   logic [265:0] sb[$];
   logic [265:0] alu_bus;
   logic [265:0] prev_bus = '0;
   logic [265:0] exp_bus;
   logic         mon_mb;

   exe_issue_sched #(.DEPTH(DEPTH), .MUL_LAT(MUL_LAT)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_opcode    (in_opcode),
      .in_oprd1     (in_oprd1),
      .in_oprd2     (in_oprd2),
      .in_oprd3     (in_oprd3),
      .in_next_rip  (in_next_rip),
      .alu_enable   (alu_enable),
      .alu_opcode   (alu_opcode),
      .alu_oprd1    (alu_oprd1),
      .alu_oprd2    (alu_oprd2),
      .alu_oprd3    (alu_oprd3),
      .alu_next_rip (alu_next_rip),
      .mem_blocked  (mem_blocked),
      .alu_branch   (alu_branch),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   assign alu_bus = {alu_opcode, alu_oprd1, alu_oprd2, alu_oprd3, alu_next_rip};

   task automatic chk(input string tag, input logic [265:0] obs, input logic [265:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic push(input logic [9:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] c, input logic [63:0] rip, input int beats);
      chk("in_ready_before_push", 266'(in_ready), 266'(1'b1));
      in_valid    = 1'b1;
      in_opcode   = op;
      in_oprd1    = a;
      in_oprd2    = b;
      in_oprd3    = c;
      in_next_rip = rip;
      for (int i = 0; i < beats; i++) sb.push_back({op, a, b, c, rip});
      tick();
      in_valid = 1'b0;
   endtask

   // Each enabled cycle not following a blocked edge is one ALU beat; blocked edges must hold the bus.
   always @(posedge clk) begin
      mon_mb = mem_blocked;
      #1;
      if (rst_n && alu_enable) begin
         if (mon_mb) begin
            chk("frozen_alu_bus", alu_bus, prev_bus);
         end else if (sb.size() == 0) begin
            chk("unexpected_issue", 266'(alu_enable), 266'(1'b0));
         end else begin
            exp_bus = sb.pop_front();
            chk("issue_payload", alu_bus, exp_bus);
         end
      end
      prev_bus = alu_bus;
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_opcode = '0;
      in_oprd1 = '0; in_oprd2 = '0; in_oprd3 = '0; in_next_rip = '0;
      mem_blocked = 1'b0; alu_branch = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_alu_enable", 266'(alu_enable), 266'(1'b0));
      chk("rst_busy", 266'(busy), 266'(1'b0));
      chk("rst_alu_bus", alu_bus, '0);
      rst_n = 1'b1;
      tick();
      chk("post_rst_in_ready", 266'(in_ready), 266'(1'b1));

      // single ADD: one-cycle latency, one-cycle enable
      push(OP_ADD, 64'd5, 64'd7, 64'd0, 64'h1004, 1);
      chk("add_e0_enable", 266'(alu_enable), 266'(1'b0));
      chk("add_e0_busy", 266'(busy), 266'(1'b1));
      tick();
      chk("add_e1_enable", 266'(alu_enable), 266'(1'b1));
      chk("add_e1_opcode", 266'(alu_opcode), 266'(OP_ADD));
      chk("add_e1_oprd1", 266'(alu_oprd1), 266'(64'd5));
      tick();
      chk("add_e2_enable", 266'(alu_enable), 266'(1'b0));
      chk("add_e2_busy", 266'(busy), 266'(1'b0));

      // IMUL held MUL_LAT cycles, ADD follows immediately
      push(OP_IMUL, 64'd3, 64'd9, 64'd0, 64'h2003, MUL_LAT);
      push(OP_ADD, 64'd1, 64'd2, 64'd0, 64'h2006, 1);
      for (int i = 0; i < MUL_LAT; i++) begin
         chk("imul_hold_enable", 266'(alu_enable), 266'(1'b1));
         chk("imul_hold_opcode", 266'(alu_opcode), 266'(OP_IMUL));
         chk("imul_hold_oprd2", 266'(alu_oprd2), 266'(64'd9));
         tick();
      end
      chk("imul_next_opcode", 266'(alu_opcode), 266'(OP_ADD));
      chk("imul_next_enable", 266'(alu_enable), 266'(1'b1));
      tick();
      chk("imul_done_busy", 266'(busy), 266'(1'b0));

      // taken branch: bubble, flush, queued ops discarded
      push(OP_JMP, 64'h40, 64'd0, 64'd0, 64'h3005, 1);
      push(OP_ADD, 64'd11, 64'd12, 64'd0, 64'h3007, 0);
      chk("jmp_t_enable", 266'(alu_enable), 266'(1'b1));
      chk("jmp_t_opcode", 266'(alu_opcode), 266'(OP_JMP));
      push(OP_OR, 64'd13, 64'd14, 64'd0, 64'h3009, 0);
      chk("jmp_t_bubble", 266'(alu_enable), 266'(1'b0));
      alu_branch = 1'b1;
      tick();
      alu_branch = 1'b0;
      chk("flush_in_ready", 266'(in_ready), 266'(1'b0));
      chk("flush_enable", 266'(alu_enable), 266'(1'b0));
      chk("flush_busy", 266'(busy), 266'(1'b1));
      in_valid = 1'b1; in_opcode = OP_XOR; in_oprd1 = 64'd99;
      tick();
      in_valid = 1'b0;
      chk("post_flush_busy", 266'(busy), 266'(1'b0));
      chk("post_flush_in_ready", 266'(in_ready), 266'(1'b1));
      tick();
      chk("post_flush_enable", 266'(alu_enable), 266'(1'b0));

      // not-taken branch: bubble then back-to-back issue
      push(OP_JMP, 64'h80, 64'd0, 64'd0, 64'h4005, 1);
      push(OP_ADD, 64'd11, 64'd12, 64'd0, 64'h4007, 1);
      push(OP_OR, 64'd13, 64'd14, 64'd0, 64'h4009, 1);
      chk("jmp_nt_bubble", 266'(alu_enable), 266'(1'b0));
      tick();
      chk("jmp_nt_add", 266'(alu_opcode), 266'(OP_ADD));
      chk("jmp_nt_add_en", 266'(alu_enable), 266'(1'b1));
      tick();
      chk("jmp_nt_or", 266'(alu_opcode), 266'(OP_OR));
      tick();
      chk("jmp_nt_idle", 266'(alu_enable), 266'(1'b0));

      // spurious branch pulse while idle is ignored
      alu_branch = 1'b1;
      tick();
      alu_branch = 1'b0;
      chk("spurious_br_busy", 266'(busy), 266'(1'b0));
      chk("spurious_br_ready", 266'(in_ready), 266'(1'b1));

      // fill FIFO under back-pressure for six edges
      mem_blocked = 1'b1;
      push(OP_SUB, 64'd21, 64'd22, 64'd23, 64'h5001, 1);
      push(OP_XOR, 64'd31, 64'd32, 64'd33, 64'h5002, 1);
      chk("blocked_full_ready", 266'(in_ready), 266'(1'b0));
      repeat (4) begin
         tick();
         chk("blocked_enable", 266'(alu_enable), 266'(1'b0));
         chk("blocked_opcode", 266'(alu_opcode), 266'(OP_OR));
      end
      mem_blocked = 1'b0;
      tick();
      chk("release_first", 266'(alu_opcode), 266'(OP_SUB));
      chk("release_ready", 266'(in_ready), 266'(1'b1));
      tick();
      chk("release_second", 266'(alu_opcode), 266'(OP_XOR));
      tick();
      chk("release_idle", 266'(busy), 266'(1'b0));

      // back-pressure while enable is high holds the issue
      push(OP_ADD, 64'd41, 64'd42, 64'd43, 64'h5101, 1);
      tick();
      mem_blocked = 1'b1;
      repeat (2) begin
         tick();
         chk("hold_enable", 266'(alu_enable), 266'(1'b1));
         chk("hold_oprd1", 266'(alu_oprd1), 266'(64'd41));
      end
      mem_blocked = 1'b0;
      tick();
      chk("hold_release_enable", 266'(alu_enable), 266'(1'b0));

      // reset in the middle of an IMUL
      push(OP_IMUL, 64'd6, 64'd7, 64'd8, 64'h6001, 2);
      tick();
      chk("mul_rst_pre_enable", 266'(alu_enable), 266'(1'b1));
      tick();
      rst_n = 1'b0;
      #1;
      chk("mul_rst_enable", 266'(alu_enable), 266'(1'b0));
      chk("mul_rst_busy", 266'(busy), 266'(1'b0));
      chk("mul_rst_bus", alu_bus, '0);
      tick();
      tick();
      rst_n = 1'b1;
      repeat (MUL_LAT + 2) tick();
      chk("mul_rst_no_reissue", 266'(alu_enable), 266'(1'b0));
      chk("mul_rst_idle", 266'(busy), 266'(1'b0));

      chk("scoreboard_drained", 266'(sb.size()), 266'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
